// File: rtl/urng_pkg.sv
// Shared definitions for the uniform-source sharing controller: LFSR taps,
// lock-up value, FSM state encoding and the single-step LFSR function.
package urng_pkg;

  localparam int LFSR_W = 32;
  localparam int TAP0   = 31;
  localparam int TAP1   = 21;
  localparam int TAP2   = 1;
  localparam int TAP3   = 0;

  // XNOR feedback never leaves the all-ones state, so that seed is refused.
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    STEP = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = ~(s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3]);
    return {s[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr32_step.sv
// 32-bit XNOR LFSR register with synchronous load and step enable.
// Load has priority over stepping.
module lfsr32_step
  import urng_pkg::*;
#(
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 32'h00A98A59
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= DEFAULT_SEED;
    end else if (load) begin
      r_state <= load_val;
    end else if (en) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/urng_share_ctrl.sv
// Round-robin arbiter sharing one LFSR among NUM_REQ consumers; each grant
// advances the LFSR STEPS_PER_WORD times and returns the word tagged by ID.
module urng_share_ctrl
  import urng_pkg::*;
#(
  parameter int                NUM_REQ        = 4,
  parameter int                ID_W           = 2,
  parameter int                STEPS_PER_WORD = 32,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED   = 32'h00A98A59
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [LFSR_W-1:0]  rnd_data,
  output logic               rnd_valid,
  output logic [ID_W-1:0]    rnd_id,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_value,
  output logic               seed_rejected,
  output logic               busy
);

  localparam int CNT_W = 8;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ID_W-1:0]     r_cur_id;
  logic [ID_W-1:0]     r_rr_last;
  logic [LFSR_W-1:0]   r_seed_reg;
  logic                r_seed_pending;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [LFSR_W-1:0]   r_rnd_data;
  logic                r_rnd_valid;
  logic [ID_W-1:0]     r_rnd_id;
  logic                r_seed_rejected;
  logic                r_busy;

  logic [LFSR_W-1:0]   w_lfsr;
  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic [LFSR_W-1:0]   w_load_val;
  logic                w_step_en;
  logic                w_load;
  logic [ID_W-1:0]     w_cand [NUM_REQ];
  logic [NUM_REQ-1:0]  w_cand_req;
  logic                w_pick_valid;
  logic [ID_W-1:0]     w_pick_id;

  assign w_step_en  = (r_state == STEP);
  assign w_load     = (r_state == SEED);
  assign w_load_val = (r_seed_reg == LFSR_LOCKUP) ? DEFAULT_SEED : r_seed_reg;
  assign w_lfsr_nxt = lfsr_next(w_lfsr);

  lfsr32_step #(
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .en       (w_step_en),
    .load     (w_load),
    .load_val (w_load_val),
    .state    (w_lfsr)
  );

  // Candidate gi is the requester gi+1 places after the last winner.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign w_cand[gi]     = ID_W'((int'(r_rr_last) + gi + 1) % NUM_REQ);
    assign w_cand_req[gi] = req[w_cand[gi]];
  end

  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_id    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand_req[k]) begin
        w_pick_valid = 1'b1;
        w_pick_id    = w_cand[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_cur_id        <= '0;
      r_rr_last       <= ID_W'(NUM_REQ - 1);
      r_seed_reg      <= '0;
      r_seed_pending  <= 1'b0;
      r_gnt           <= '0;
      r_rnd_data      <= '0;
      r_rnd_valid     <= 1'b0;
      r_rnd_id        <= '0;
      r_seed_rejected <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_rnd_valid     <= 1'b0;
      r_gnt           <= '0;
      r_seed_rejected <= 1'b0;

      if (seed_load) begin
        r_seed_reg     <= seed_value;
        r_seed_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (r_seed_pending) begin
            r_state <= SEED;
            r_busy  <= 1'b1;
          end else if (w_pick_valid) begin
            r_cur_id <= w_pick_id;
            r_cnt    <= CNT_W'(STEPS_PER_WORD - 1);
            r_state  <= STEP;
            r_busy   <= 1'b1;
          end
        end
        SEED: begin
          r_seed_rejected <= (r_seed_reg == LFSR_LOCKUP);
          // A seed arriving in this very cycle stays pending for next time.
          if (!seed_load) begin
            r_seed_pending <= 1'b0;
          end
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        STEP: begin
          if (r_cnt == '0) begin
            r_state     <= OUT;
            r_rnd_valid <= 1'b1;
            r_rnd_data  <= w_lfsr_nxt;
            r_rnd_id    <= r_cur_id;
            r_gnt       <= NUM_REQ'(1) << r_cur_id;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        OUT: begin
          r_rr_last <= r_cur_id;
          r_state   <= IDLE;
          r_busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign rnd_data      = r_rnd_data;
  assign rnd_valid     = r_rnd_valid;
  assign rnd_id        = r_rnd_id;
  assign seed_rejected = r_seed_rejected;
  assign busy          = r_busy;

endmodule

// File: tb/tb_urng_share_ctrl.sv
// Directed bench: one instance with single-step words, one with default
// 32-step words, checked against a local LFSR model.
module tb_urng_share_ctrl;

  localparam logic [31:0] DSEED = 32'h00A98A59;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with STEPS_PER_WORD = 1
  logic        rst1 = 1'b1;
  logic [3:0]  req1 = '0;
  logic [3:0]  gnt1;
  logic [31:0] data1;
  logic        valid1;
  logic [1:0]  id1;
  logic        sload1 = 1'b0;
  logic [31:0] sval1 = '0;
  logic        rej1;
  logic        busy1;

  // Instance with default parameters
  logic        rst32 = 1'b1;
  logic [3:0]  req32 = '0;
  logic [3:0]  gnt32;
  logic [31:0] data32;
  logic        valid32;
  logic [1:0]  id32;
  logic        sload32 = 1'b0;
  logic [31:0] sval32 = '0;
  logic        rej32;
  logic        busy32;

  urng_share_ctrl #(.STEPS_PER_WORD(1)) dut1 (
    .clk(clk), .reset(rst1), .req(req1), .gnt(gnt1), .rnd_data(data1),
    .rnd_valid(valid1), .rnd_id(id1), .seed_load(sload1), .seed_value(sval1),
    .seed_rejected(rej1), .busy(busy1)
  );

  urng_share_ctrl dut32 (
    .clk(clk), .reset(rst32), .req(req32), .gnt(gnt32), .rnd_data(data32),
    .rnd_valid(valid32), .rnd_id(id32), .seed_load(sload32), .seed_value(sval32),
    .seed_rejected(rej32), .busy(busy32)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rej_cnt = 0;

  always @(posedge clk) begin
    if (rej32) rej_cnt <= rej_cnt + 1;
  end

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
  endfunction

  function automatic logic [31:0] ref_n(input logic [31:0] s, input int n);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = ref_step(t);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic wait32(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!valid32 && cyc < 200);
    if (!valid32) cyc = -1;
  endtask

  initial begin
    logic [31:0] m;
    int cyc;
    int vcount;
    logic [3:0] exp_gnt;

    tick(); tick(); tick();
    chk("rst_gnt", 32'(gnt1), 32'h0);
    chk("rst_valid", 32'(valid1), 32'h0);
    chk("rst_data", data1, 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_rej", 32'(rej32), 32'h0);
    rst1 = 1'b0;
    rst32 = 1'b0;
    tick();
    chk("idle_busy", 32'(busy1), 32'h0);

    // Single-step words
    req1 = 4'b0001;
    tick();
    chk("s1_step_valid", 32'(valid1), 32'h0);
    chk("s1_step_busy", 32'(busy1), 32'h1);
    tick();
    $display("s1 word0: valid=%0d id=%0d gnt=%b data=%08h", valid1, id1, gnt1, data1);
    chk("s1_w0_valid", 32'(valid1), 32'h1);
    chk("s1_w0_gnt", 32'(gnt1), 32'h1);
    chk("s1_w0_id", 32'(id1), 32'h0);
    chk("s1_w0_data", data1, 32'h015314B3);
    req1 = 4'b0000;
    tick();
    chk("s1_after_valid", 32'(valid1), 32'h0);
    chk("s1_after_gnt", 32'(gnt1), 32'h0);
    chk("s1_hold_data", data1, 32'h015314B3);
    req1 = 4'b0001;
    tick(); tick();
    $display("s1 word1: valid=%0d id=%0d data=%08h", valid1, id1, data1);
    chk("s1_w1_valid", 32'(valid1), 32'h1);
    chk("s1_w1_data", data1, 32'h02A62967);
    req1 = 4'b0000;
    tick();

    // One-cycle pulse on req[1] is still served, exactly once
    req1 = 4'b0010;
    tick();
    req1 = 4'b0000;
    tick();
    $display("s1 pulse: valid=%0d id=%0d gnt=%b data=%08h", valid1, id1, gnt1, data1);
    chk("pulse_valid", 32'(valid1), 32'h1);
    chk("pulse_gnt", 32'(gnt1), 32'h2);
    chk("pulse_id", 32'(id1), 32'h1);
    chk("pulse_data", data1, ref_n(32'h02A62967, 1));
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid1) vcount++;
    end
    chk("pulse_no_repeat", 32'(vcount), 32'h0);

    // Round-robin with all requests held
    m = DSEED;
    req32 = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      wait32(cyc);
      m = ref_n(m, 32);
      exp_gnt = 4'b0001 << (w % 4);
      $display("rr word%0d: cycles=%0d id=%0d gnt=%b data=%08h", w, cyc, id32, gnt32, data32);
      chk("rr_spacing", 32'(cyc), (w == 0) ? 32'd33 : 32'd34);
      chk("rr_id", 32'(id32), 32'(w % 4));
      chk("rr_gnt", 32'(gnt32), 32'(exp_gnt));
      chk("rr_data", data32, m);
    end

    // Reseed during STEP: in-flight word unaffected, next word uses new seed
    req32 = 4'b0001;
    tick(); tick(); tick(); tick(); tick();
    chk("seed_busy", 32'(busy32), 32'h1);
    sload32 = 1'b1;
    sval32 = 32'h12345678;
    tick();
    sload32 = 1'b0;
    wait32(cyc);
    m = ref_n(m, 32);
    $display("seed old word: id=%0d data=%08h", id32, data32);
    chk("seed_old_data", data32, m);
    chk("seed_old_id", 32'(id32), 32'h0);
    wait32(cyc);
    $display("seed new word: cycles=%0d id=%0d data=%08h", cyc, id32, data32);
    chk("seed_new_spacing", 32'(cyc), 32'd36);
    chk("seed_new_data", data32, ref_n(32'h12345678, 32));
    req32 = 4'b0000;
    chk("seed_no_reject", 32'(rej_cnt), 32'h0);
    tick();

    // Lock-up seed is rejected
    sload32 = 1'b1;
    sval32 = 32'hFFFFFFFF;
    tick();
    sload32 = 1'b0;
    tick(); tick(); tick(); tick();
    $display("lockup seed: reject pulses=%0d", rej_cnt);
    chk("lockup_reject_cycles", 32'(rej_cnt), 32'h1);
    req32 = 4'b0100;
    wait32(cyc);
    $display("lockup word: cycles=%0d id=%0d data=%08h", cyc, id32, data32);
    chk("lockup_latency", 32'(cyc), 32'd33);
    chk("lockup_id", 32'(id32), 32'h2);
    chk("lockup_data", data32, ref_n(DSEED, 32));
    req32 = 4'b0000;
    tick();

    // Reset mid-STEP with req[2]; afterwards arbitration restarts from 0
    req32 = 4'b0100;
    for (int i = 0; i < 10; i++) tick();
    chk("abort_busy", 32'(busy32), 32'h1);
    rst32 = 1'b1;
    req32 = 4'b0110;
    tick();
    $display("reset mid-step: valid=%0d gnt=%b data=%08h busy=%0d", valid32, gnt32, data32, busy32);
    chk("abort_valid", 32'(valid32), 32'h0);
    chk("abort_gnt", 32'(gnt32), 32'h0);
    chk("abort_data", data32, 32'h0);
    chk("abort_busy0", 32'(busy32), 32'h0);
    rst32 = 1'b0;
    wait32(cyc);
    $display("post-reset word: cycles=%0d id=%0d gnt=%b data=%08h", cyc, id32, gnt32, data32);
    chk("post_rst_latency", 32'(cyc), 32'd33);
    chk("post_rst_id", 32'(id32), 32'h1);
    chk("post_rst_gnt", 32'(gnt32), 32'h2);
    chk("post_rst_data", data32, ref_n(DSEED, 32));
    req32 = 4'b0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
